wb_pipe_buffer: RTL

Parametrised MEM→WB pipeline buffer replacing the single-entry MEM/WB register. It holds up to DEPTH completed writeback results in a FIFO with valid/ready handshakes on both sides, so the MEM stage can keep retiring while writeback stalls. It also offers a combinational forwarding lookup over buffered entries, and sits between the MEM stage and the register-file write port.

---
 rtl/wb_pipe_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_pipe_buffer.sv
// wb_pipe_buffer
//   MEM->WB pipeline buffer: a DEPTH-entry FIFO of completed writeback
//   results with valid/ready handshakes on both sides, plus a combinational
//   forwarding lookup over the occupied entries.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous clear of all entries (beats push/pop)
//   in_valid/in_ready   MEM side handshake; in_wd/in_wreg/in_wdata payload
//   out_valid/out_ready WB side handshake; out_wd/out_wreg/out_wdata head
//   count               occupied entries
//   fwd_addr            forwarding lookup address
//   fwd_hit/fwd_data    youngest occupied entry writing fwd_addr
module wb_pipe_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_wd,
    input  logic                       in_wreg,
    input  logic [DATA_W-1:0]          in_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_wd,
    output logic                       out_wreg,
    output logic [DATA_W-1:0]          out_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] wd_q    [DEPTH];
    logic [ADDR_W-1:0] wd_d    [DEPTH];
    logic              wreg_q  [DEPTH];
    logic              wreg_d  [DEPTH];
    logic [DATA_W-1:0] wdata_q [DEPTH];
    logic [DATA_W-1:0] wdata_d [DEPTH];
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push;
    logic pop;

    // Handshake flags come from registered count only, so there is no
    // combinational path from in_valid/out_ready back to them.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    // Empty buffer presents the write-disable encoding, never a bypass.
    assign out_wd    = out_valid ? wd_q[rptr_q]    : '0;
    assign out_wreg  = out_valid ? wreg_q[rptr_q]  : 1'b0;
    assign out_wdata = out_valid ? wdata_q[rptr_q] : '0;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        wd_d    = wd_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                wreg_d[i] = 1'b0;
            end
        end else begin
            if (push) begin
                wd_d[wptr_q]    = in_wd;
                // x0 writes are squashed on entry so neither WB nor the
                // forwarding scan ever sees them as real writes.
                wreg_d[wptr_q]  = in_wreg & (in_wd != '0);
                wdata_d[wptr_q] = in_wdata;
                wptr_d          = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wd_q[i]    <= '0;
                wreg_q[i]  <= 1'b0;
                wdata_q[i] <= '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                wd_q[i]    <= wd_d[i];
                wreg_q[i]  <= wreg_d[i];
                wdata_q[i] <= wdata_d[i];
            end
        end
    end

    // Walk occupied entries oldest to youngest; a later match overwrites an
    // earlier one, leaving the youngest match in fwd_data.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && wreg_q[idx] &&
                (wd_q[idx] == fwd_addr) && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = wdata_q[idx];
            end
        end
    end

endmodule
